dma_reg_programmer: RTL and testbench
=====================================

Name: dma_reg_programmer

Overview:
- Register-bus initiator that programs one DMA channel's register block: intr @ +0x0, control @ +0x4, io_address @ +0x8, mem_address @ +0xC, extra_info @ +0x10.
- Accepts a five-word descriptor over a valid/ready handshake and issues a fixed sequence of single-cycle writes on the addr/wr_en/rd_en/wdata/rdata bus.
- Control is written last, so the channel is fully configured before it is enabled.
- Sits between the host/sequencer logic and the DMA register slave.

Parameters:
- ADDR_WIDTH, 32, register-bus address width.
- DATA_WIDTH, 32, register-bus and descriptor word width.
- BASE_ADDR, 32'h400, address of the intr register; the other registers are at fixed offsets from it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  descriptor valid.
- cmd_ready  output  1  block can accept a descriptor.
- cmd_intr  input  DATA_WIDTH  value for intr.
- cmd_control  input  DATA_WIDTH  value for control.
- cmd_io_addr  input  DATA_WIDTH  value for io_address.
- cmd_mem_addr  input  DATA_WIDTH  value for mem_address.
- cmd_extra  input  DATA_WIDTH  value for extra_info.
- addr  output  ADDR_WIDTH  register-bus address.
- wr_en  output  1  register-bus write strobe.
- rd_en  output  1  register-bus read strobe.
- wdata  output  DATA_WIDTH  register-bus write data.
- rdata  input  DATA_WIDTH  register-bus read data; valid in the cycle after rd_en.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse when a command completes.
- error  output  1  readback mismatch; valid while done is high.
- err_idx  output  3  beat index (0-4) of the first mismatch.

Behaviour:
- Reset (rst_n=1, async): state IDLE; cmd_ready=1 only after reset is released. During reset all other outputs are 0, including addr, wdata, wr_en, rd_en, busy, done, error and err_idx. All shadow registers are cleared.
- All outputs are registered. wr_en and rd_en are never high in the same cycle.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready at an edge: capture all five cmd_* words into shadow registers, set beat index=0, go to WRITE.
  - cmd_* inputs are ignored at all other times.
- WRITE (one beat per cycle, 5 cycles):
  - beat 0: addr=BASE+0x8, wdata=io_addr.
  - beat 1: addr=BASE+0xC, wdata=mem_addr.
  - beat 2: addr=BASE+0x10, wdata=extra.
  - beat 3: addr=BASE+0x0, wdata=intr.
  - beat 4: addr=BASE+0x4, wdata=control.
  - wr_en=1 for each beat. After beat 4: go to DONE, or to RD_ISSUE when VERIFY_EN is defined.
- DONE: lasts one cycle. done=1; addr, wdata and strobes are 0; cmd_ready=0. Next state IDLE.
- busy=1 in every state except IDLE.
- Latency without VERIFY_EN: accept at edge E0; write beats occupy cycles 1-5; done is high in cycle 6; cmd_ready returns high in cycle 7.
- Back-to-back commands: a descriptor presented while busy waits, held valid until the next IDLE cycle.
- Address arithmetic: BASE_ADDR plus offset, truncated to ADDR_WIDTH.
- err_idx is a 3-bit beat index.
- Reset asserted mid-command: sequence abandoned immediately, outputs go to their reset values, no done pulse, partial writes are not undone.

Optional Feature:
- Macro: DMA_REG_PROG_VERIFY_EN.
- When defined, readback follows the writes, in the same beat order:
  - RD_ISSUE: rd_en=1, addr = that beat's address.
  - RD_WAIT: rd_en=0; at the end of the cycle, rdata is compared with the shadow word.
  - 10 cycles in total, then DONE.
- On the first mismatch, error is latched sticky for the current command and err_idx is set to the beat number.
- error and err_idx are cleared on the next command acceptance.
- Latency with the feature: done is high in cycle 16 after acceptance.
- When the macro is not defined: no read states exist, rd_en, error and err_idx are tied to 0, and the rdata port is present but unused.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles then release -> cmd_ready=1; wr_en, rd_en, busy and done are 0; addr=0.
- Single command: intr=1, control=5, io=0x1000, mem=0x2000, extra=0xAA -> writes in cycles 1-5 go to 0x408/0x1000, 0x40C/0x2000, 0x410/0xAA, 0x400/1, 0x404/5. done pulses in cycle 6, error=0.
- Backpressure: hold cmd_valid=1 with a second descriptor while busy -> accepted only in the first IDLE cycle after done; its first write beat comes 2 cycles after done.
- Mid-command reset: assert rst_n during beat 2 -> wr_en drops asynchronously, no done pulse, a new command afterwards completes normally.
- VERIFY_EN pass: slave model returns the written values -> 5 rd_en pulses to 0x408, 0x40C, 0x410, 0x400, 0x404 in alternating cycles; done in cycle 16 with error=0.
- VERIFY_EN fail: slave model corrupts mem_address to 0x2004 -> done with error=1 and err_idx=1; the next command starts with error cleared.

Source files
------------

// File: rtl/dma_reg_programmer.sv
// Register-bus initiator: programs one DMA channel from a five-word descriptor, control last.
// Optional readback verification is enabled with `define DMA_REG_PROG_VERIFY_EN.
module dma_reg_programmer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h400)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_intr,
  input  logic [DATA_WIDTH-1:0] cmd_control,
  input  logic [DATA_WIDTH-1:0] cmd_io_addr,
  input  logic [DATA_WIDTH-1:0] cmd_mem_addr,
  input  logic [DATA_WIDTH-1:0] cmd_extra,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_idx
);

  localparam int       NumBeats = 5;
  localparam bit [2:0] LastBeat = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
`ifdef DMA_REG_PROG_VERIFY_EN
    StRdIssue = 3'd2,
    StRdWait  = 3'd3,
`endif
    StDone    = 3'd4
  } state_e;

  // Shadow words are stored in beat order: io, mem, extra, intr, control.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [2:0] beat);
    logic [4:0] off;
    case (beat)
      3'd0:    off = 5'h08;
      3'd1:    off = 5'h0C;
      3'd2:    off = 5'h10;
      3'd3:    off = 5'h00;
      3'd4:    off = 5'h04;
      default: off = 5'h00;
    endcase
    return BASE_ADDR + ADDR_WIDTH'(off);
  endfunction

  state_e                r_state, w_state_d;
  logic [2:0]            r_beat, w_beat_d;
  logic [DATA_WIDTH-1:0] r_shadow [NumBeats];
  logic [DATA_WIDTH-1:0] w_shadow_d [NumBeats];
  logic                  w_accept;

  logic                  r_cmd_ready, w_cmd_ready_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic                  r_wr_en, w_wr_en_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
`ifdef DMA_REG_PROG_VERIFY_EN
  logic                  r_rd_en, w_rd_en_d;
  logic                  r_error, w_error_d;
  logic [2:0]            r_err_idx, w_err_idx_d;
`endif

  // r_cmd_ready is only ever high in StIdle.
  assign w_accept = cmd_valid && r_cmd_ready;

  always_comb begin
    w_state_d  = r_state;
    w_beat_d   = r_beat;
    w_shadow_d = r_shadow;
`ifdef DMA_REG_PROG_VERIFY_EN
    w_error_d   = r_error;
    w_err_idx_d = r_err_idx;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_shadow_d[0] = cmd_io_addr;
          w_shadow_d[1] = cmd_mem_addr;
          w_shadow_d[2] = cmd_extra;
          w_shadow_d[3] = cmd_intr;
          w_shadow_d[4] = cmd_control;
          w_beat_d      = 3'd0;
          w_state_d     = StWrite;
`ifdef DMA_REG_PROG_VERIFY_EN
          w_error_d     = 1'b0;
          w_err_idx_d   = 3'd0;
`endif
        end
      end
      StWrite: begin
        if (r_beat == LastBeat) begin
`ifdef DMA_REG_PROG_VERIFY_EN
          w_state_d = StRdIssue;
          w_beat_d  = 3'd0;
`else
          w_state_d = StDone;
`endif
        end else begin
          w_beat_d = r_beat + 3'd1;
        end
      end
`ifdef DMA_REG_PROG_VERIFY_EN
      StRdIssue: w_state_d = StRdWait;
      StRdWait: begin
        // Only the first mismatch of a command is recorded.
        if ((rdata != r_shadow[r_beat]) && !r_error) begin
          w_error_d   = 1'b1;
          w_err_idx_d = r_beat;
        end
        if (r_beat == LastBeat) begin
          w_state_d = StDone;
        end else begin
          w_state_d = StRdIssue;
          w_beat_d  = r_beat + 3'd1;
        end
      end
`endif
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    w_addr_d  = '0;
    w_wdata_d = '0;
    w_wr_en_d = 1'b0;
`ifdef DMA_REG_PROG_VERIFY_EN
    w_rd_en_d = 1'b0;
`endif
    case (w_state_d)
      StWrite: begin
        w_addr_d  = beat_addr(w_beat_d);
        w_wdata_d = w_shadow_d[w_beat_d];
        w_wr_en_d = 1'b1;
      end
`ifdef DMA_REG_PROG_VERIFY_EN
      StRdIssue: begin
        w_addr_d  = beat_addr(w_beat_d);
        w_rd_en_d = 1'b1;
      end
`endif
      default: ;
    endcase
    w_busy_d      = (w_state_d != StIdle);
    w_done_d      = (w_state_d == StDone);
    w_cmd_ready_d = (w_state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      for (int i = 0; i < NumBeats; i++) begin
        r_shadow[i] <= '0;
      end
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef DMA_REG_PROG_VERIFY_EN
      r_rd_en     <= 1'b0;
      r_error     <= 1'b0;
      r_err_idx   <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_beat      <= w_beat_d;
      r_shadow    <= w_shadow_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_wr_en     <= w_wr_en_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
`ifdef DMA_REG_PROG_VERIFY_EN
      r_rd_en     <= w_rd_en_d;
      r_error     <= w_error_d;
      r_err_idx   <= w_err_idx_d;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_en     = r_wr_en;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
`ifdef DMA_REG_PROG_VERIFY_EN
  assign rd_en     = r_rd_en;
  assign error     = r_error;
  assign err_idx   = r_err_idx;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^rdata;
  assign rd_en          = 1'b0;
  assign error          = 1'b0;
  assign err_idx        = 3'd0;
`endif

endmodule

// File: tb/tb_dma_reg_programmer.sv
// Self-checking bench for dma_reg_programmer: random descriptors against a cycle-level model.
// Also exercises the readback path when DMA_REG_PROG_VERIFY_EN is defined.
module tb_dma_reg_programmer;

  localparam logic [31:0] Base = 32'h400;
`ifdef DMA_REG_PROG_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif
  localparam int DoneCyc = Verify ? 16 : 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_intr = '0, cmd_control = '0, cmd_io_addr = '0, cmd_mem_addr = '0;
  logic [31:0] cmd_extra = '0;
  logic [31:0] addr, wdata;
  logic [31:0] rdata = '0;
  logic        wr_en, rd_en, busy, done, error;
  logic [2:0]  err_idx;

  int total = 0;
  int bad   = 0;

  // Write order: io_address, mem_address, extra_info, intr, control.
  logic [31:0] off_tab [5] = '{32'h8, 32'hC, 32'h10, 32'h0, 32'h4};
  // Descriptor array order is intr, control, io, mem, extra.
  int          ord_tab [5] = '{2, 3, 4, 0, 1};

  bit          corrupt_en = 1'b0;
  logic [31:0] slave_mem [8];

  always #5 clk = ~clk;

  dma_reg_programmer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_intr     (cmd_intr),
    .cmd_control  (cmd_control),
    .cmd_io_addr  (cmd_io_addr),
    .cmd_mem_addr (cmd_mem_addr),
    .cmd_extra    (cmd_extra),
    .addr         (addr),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_idx      (err_idx)
  );

  // Register slave: stores writes, returns read data one cycle after rd_en.
  always @(posedge clk) begin
    if (wr_en) slave_mem[addr[4:2]] <= wdata;
    if (rd_en) rdata <= slave_mem[addr[4:2]] +
                        ((corrupt_en && addr == Base + 32'hC) ? 32'd4 : 32'd0);
  end

  // Expected {cmd_ready, busy, done, wr_en, rd_en}, addr and wdata k cycles after acceptance.
  function automatic void model_cycle(input int k, input logic [31:0] dd [5],
                                      output logic [4:0] ef, output logic [31:0] ea,
                                      output logic [31:0] ew);
    int r;
    ea = '0;
    ew = '0;
    if (k >= 1 && k <= 5) begin
      ef = 5'b01010;
      ea = Base + off_tab[k-1];
      ew = dd[ord_tab[k-1]];
    end else if (k < DoneCyc) begin
      r = k - 6;
      if (r % 2 == 0) begin
        ef = 5'b01001;
        ea = Base + off_tab[r/2];
      end else begin
        ef = 5'b01000;
      end
    end else if (k == DoneCyc) begin
      ef = 5'b01100;
    end else begin
      ef = 5'b10000;
    end
  endfunction

  task automatic drive_desc(input logic [31:0] dd [5]);
    cmd_intr     = dd[0];
    cmd_control  = dd[1];
    cmd_io_addr  = dd[2];
    cmd_mem_addr = dd[3];
    cmd_extra    = dd[4];
  endtask

  task automatic rand_desc(output logic [31:0] dd [5]);
    for (int i = 0; i < 5; i++) dd[i] = $urandom();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b0 || addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold got ready/busy/done/wr/rd=%b addr=%h want 00000 addr=0",
               {cmd_ready, busy, done, wr_en, rd_en}, addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b10000 || addr !== 32'h0 ||
        wdata !== 32'h0 || {error, err_idx} !== 4'h0) begin
      bad++;
      $display("FAIL reset_release got flags=%b addr=%h wdata=%h err=%b/%0d want 10000 0 0 0/0",
               {cmd_ready, busy, done, wr_en, rd_en}, addr, wdata, error, err_idx);
    end
  endtask

  task automatic test_single();
    logic [31:0] dd [5];
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    dd    = '{32'h1, 32'h5, 32'h1000, 32'h2000, 32'hAA};
    exp_a = '{32'h408, 32'h40C, 32'h410, 32'h400, 32'h404};
    exp_d = '{32'h1000, 32'h2000, 32'hAA, 32'h1, 32'h5};
    drive_desc(dd);
    cmd_valid = 1'b1;
    for (int k = 1; k <= DoneCyc + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (k <= 5) begin
        total++;
        if (wr_en !== 1'b1 || rd_en !== 1'b0 || addr !== exp_a[k-1] || wdata !== exp_d[k-1]) begin
          bad++;
          $display("FAIL single_beat%0d got wr=%b rd=%b addr=%h data=%h want 1 0 %h %h",
                   k - 1, wr_en, rd_en, addr, wdata, exp_a[k-1], exp_d[k-1]);
        end
      end else if (k == DoneCyc) begin
        total++;
        if (done !== 1'b1 || error !== 1'b0 || wr_en !== 1'b0 || addr !== 32'h0) begin
          bad++;
          $display("FAIL single_done got done=%b err=%b wr=%b addr=%h want 1 0 0 0",
                   done, error, wr_en, addr);
        end
      end else if (k == DoneCyc + 1) begin
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL single_idle got ready=%b done=%b busy=%b want 1 0 0",
                   cmd_ready, done, busy);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] dd [5];
    logic [31:0] junk [5];
    logic [4:0]  ef;
    logic [31:0] ea, ew;
    for (int c = 0; c < n; c++) begin
      // Idle gap with garbage on the cmd bus and valid low.
      repeat ($urandom_range(0, 3)) begin
        rand_desc(junk);
        drive_desc(junk);
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b10000) begin
          bad++;
          $display("FAIL random_gap got flags=%b want 10000", {cmd_ready, busy, done, wr_en, rd_en});
        end
      end
      rand_desc(dd);
      drive_desc(dd);
      cmd_valid = 1'b1;
      for (int k = 1; k <= DoneCyc + 1; k++) begin
        @(negedge clk);
        if (k == 1) begin
          cmd_valid = 1'b0;
          rand_desc(junk);
          drive_desc(junk);
        end
        model_cycle(k, dd, ef, ea, ew);
        total++;
        if ({cmd_ready, busy, done, wr_en, rd_en} !== ef) begin
          bad++;
          $display("FAIL random_flags cmd=%0d cyc=%0d got=%b want=%b",
                   c, k, {cmd_ready, busy, done, wr_en, rd_en}, ef);
        end
        if (ef[2] || ef[1] || ef[0]) begin
          total++;
          if (addr !== ea) begin
            bad++;
            $display("FAIL random_addr cmd=%0d cyc=%0d got=%h want=%h", c, k, addr, ea);
          end
        end
        if (ef[2] || ef[1]) begin
          total++;
          if (wdata !== ew) begin
            bad++;
            $display("FAIL random_wdata cmd=%0d cyc=%0d got=%h want=%h", c, k, wdata, ew);
          end
        end
        if (ef[2]) begin
          total++;
          if ({error, err_idx} !== 4'h0) begin
            bad++;
            $display("FAIL random_error cmd=%0d got=%b/%0d want 0/0", c, error, err_idx);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1 [5];
    logic [31:0] d2 [5];
    logic [4:0]  ef;
    logic [31:0] ea, ew;
    int          k;
    rand_desc(d1);
    rand_desc(d2);
    drive_desc(d1);
    cmd_valid = 1'b1;
    for (int c = 1; c <= 2 * (DoneCyc + 1); c++) begin
      @(negedge clk);
      if (c == 1) drive_desc(d2);
      if (c <= DoneCyc + 1) begin
        k = c;
        model_cycle(k, d1, ef, ea, ew);
      end else begin
        k = c - (DoneCyc + 1);
        model_cycle(k, d2, ef, ea, ew);
      end
      if (c == DoneCyc + 2) cmd_valid = 1'b0;
      total++;
      if ({cmd_ready, busy, done, wr_en, rd_en} !== ef) begin
        bad++;
        $display("FAIL b2b_flags cyc=%0d got=%b want=%b", c, {cmd_ready, busy, done, wr_en, rd_en}, ef);
      end
      if (ef[1]) begin
        total++;
        if (addr !== ea || wdata !== ew) begin
          bad++;
          $display("FAIL b2b_write cyc=%0d got=%h/%h want=%h/%h", c, addr, wdata, ea, ew);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] dd [5];
    logic [4:0]  ef;
    logic [31:0] ea, ew;
    rand_desc(dd);
    drive_desc(dd);
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    total++;
    if (wr_en !== 1'b1 || addr !== Base + 32'h10) begin
      bad++;
      $display("FAIL midrst_beat2 got wr=%b addr=%h want 1 %h", wr_en, addr, Base + 32'h10);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b0 || addr !== 32'h0 || wdata !== 32'h0) begin
      bad++;
      $display("FAIL midrst_async got flags=%b addr=%h wdata=%h want 00000 0 0",
               {cmd_ready, busy, done, wr_en, rd_en}, addr, wdata);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || wr_en !== 1'b0) begin
        bad++;
        $display("FAIL midrst_hold got done=%b wr=%b want 0 0", done, wr_en);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_release got ready=%b done=%b want 1 0", cmd_ready, done);
    end
    rand_desc(dd);
    drive_desc(dd);
    cmd_valid = 1'b1;
    for (int k = 1; k <= DoneCyc + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      model_cycle(k, dd, ef, ea, ew);
      total++;
      if ({cmd_ready, busy, done, wr_en, rd_en} !== ef ||
          ((ef[1] || ef[0]) && addr !== ea) || (ef[1] && wdata !== ew)) begin
        bad++;
        $display("FAIL midrst_recover cyc=%0d got=%b %h %h want=%b %h %h",
                 k, {cmd_ready, busy, done, wr_en, rd_en}, addr, wdata, ef, ea, ew);
      end
    end
  endtask

`ifdef DMA_REG_PROG_VERIFY_EN
  task automatic test_verify_fail();
    logic [31:0] dd [5];
    dd = '{32'h1, 32'h5, 32'h1000, 32'h2000, 32'hAA};
    corrupt_en = 1'b1;
    drive_desc(dd);
    cmd_valid = 1'b1;
    for (int k = 1; k <= DoneCyc; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    total++;
    if (done !== 1'b1 || error !== 1'b1 || err_idx !== 3'd1) begin
      bad++;
      $display("FAIL verify_err got done=%b err=%b idx=%0d want 1 1 1", done, error, err_idx);
    end
    corrupt_en = 1'b0;
    @(negedge clk);
    rand_desc(dd);
    drive_desc(dd);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (error !== 1'b0 || err_idx !== 3'd0) begin
      bad++;
      $display("FAIL verify_clear got err=%b idx=%0d want 0 0", error, err_idx);
    end
    for (int k = 2; k <= DoneCyc + 1; k++) begin
      @(negedge clk);
      if (k == DoneCyc) begin
        total++;
        if (done !== 1'b1 || error !== 1'b0) begin
          bad++;
          $display("FAIL verify_next got done=%b err=%b want 1 0", done, error);
        end
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) slave_mem[i] = '0;
    test_reset();
    test_single();
    test_random(12);
    test_back_to_back();
    test_mid_reset();
`ifdef DMA_REG_PROG_VERIFY_EN
    test_verify_fail();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
